cpu_run_checker: RTL and testbench

- Synthesizable self-check block that sits beside CPU_SingleCycle and automates end-of-program checking of a run.
- Counts cycles and watches PC and Overflow until PC reaches a parametrised end address, or until a timeout.
- Then scans an N-element array in data memory through a read port and checks that it is strictly ordered.
- Reports pass/fail, a fail code, the failing index and the cycle count, so regressions need no hard-coded bench checks.

---
 rtl/cpu_run_checker.sv | 184 ++++++++++++++++++
 tb/tb_cpu_run_checker.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_checker.sv
// cpu_run_checker
// Purpose: self-check block placed beside a single-cycle CPU. It counts
// cycles while the program runs and watches PC and Overflow. When PC reaches
// END_PC, or on a timeout, the run phase ends. It then scans an ARR_LEN
// element array in data memory and checks that the array is strictly ordered.
// It reports a verdict, a fail code, the failing index and the cycle count.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset, shared with the CPU
//   PC           CPU program counter (byte address)
//   Overflow     CPU ALU overflow flag
//   dm_rd_en     data-memory read strobe (SCAN only)
//   dm_addr      byte address of the read (0 outside SCAN)
//   dm_rdata     read data, valid the cycle after dm_rd_en
//   done         check finished, sticky until reset
//   pass         done and no failure recorded
//   fail_code    0 none, 1 unexpected overflow, 2 timeout,
//                3 missing overflow, 4 order violation
//   fail_index   index i where elem[i-1],elem[i] breaks the order (code 4)
//   cycle_count  RUN cycles elapsed, saturating, frozen after RUN
//
// state | meaning
// RUN   | program executing; counting cycles, watching PC and Overflow
// SCAN  | pipelined array read-back and order comparison
// DONE  | verdict held until reset; CPU inputs ignored

module cpu_run_checker #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ARR_BASE   = 512,
  parameter int ARR_LEN    = 12,
  parameter int END_PC     = 104,
  parameter int EXPECT_OVF = 1,
  parameter int ORDER      = 0,
  parameter int SIGNED_CMP = 1,
  parameter int TIMEOUT    = 100000,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] PC,
  input  logic                  Overflow,
  output logic                  dm_rd_en,
  output logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  done,
  output logic                  pass,
  output logic [2:0]            fail_code,
  output logic [15:0]           fail_index,
  output logic [CNT_WIDTH-1:0]  cycle_count
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] FC_NONE    = 3'd0;
  localparam logic [2:0] FC_OVF     = 3'd1;
  localparam logic [2:0] FC_TIMEOUT = 3'd2;
  localparam logic [2:0] FC_MISSOVF = 3'd3;
  localparam logic [2:0] FC_ORDER   = 3'd4;

  // One extra index bit so the scan index can reach ARR_LEN itself.
  localparam int IDX_W = 17;
  // With fewer than two elements there is nothing to compare, so the scan
  // collapses to a single cycle.
  localparam int SCAN_LAST = (ARR_LEN <= 1) ? 0 : ARR_LEN;

  localparam logic [IDX_W-1:0]      LEN_I   = IDX_W'(ARR_LEN);
  localparam logic [IDX_W-1:0]      LAST_I  = IDX_W'(SCAN_LAST);
  localparam logic [IDX_W-1:0]      ONE_I   = IDX_W'(1);
  localparam logic [IDX_W-1:0]      TWO_I   = IDX_W'(2);
  localparam logic [ADDR_WIDTH-1:0] BASE_A  = ADDR_WIDTH'(ARR_BASE);
  localparam logic [ADDR_WIDTH-1:0] END_A   = ADDR_WIDTH'(END_PC);
  // Timeout compared in 64 bits so a TIMEOUT beyond the counter range never
  // aliases onto a truncated value; a saturated counter simply never times out.
  localparam logic [63:0]           TO_LAST = 64'(TIMEOUT) - 64'd1;

  logic [1:0]            state;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] prev_data;

  logic [CNT_WIDTH-1:0]  cnt_next;
  logic                  end_hit;
  logic                  timeout_hit;
  logic                  rd_issue;
  logic                  data_valid;
  logic                  cmp_valid;
  logic                  prev_lt_cur;
  logic                  prev_gt_cur;
  logic                  in_order;

  assign cnt_next    = (cycle_count == '1) ? cycle_count : cycle_count + 1'b1;
  assign end_hit     = (PC == END_A);
  assign timeout_hit = (64'(cnt_next) == TO_LAST);

  // In SCAN cycle idx the read for element idx is issued (while idx < ARR_LEN)
  // and dm_rdata carries element idx-1, read in the previous cycle.
  assign rd_issue   = (state == ST_SCAN) && (idx < LEN_I);
  assign data_valid = (state == ST_SCAN) && (idx != '0) && (idx <= LEN_I);
  assign cmp_valid  = data_valid && (idx >= TWO_I);

  assign dm_rd_en = rd_issue;
  assign dm_addr  = rd_issue ? (BASE_A + (ADDR_WIDTH'(idx) << 2)) : '0;

  always_comb begin
    prev_lt_cur = 1'b0;
    prev_gt_cur = 1'b0;
    if (SIGNED_CMP != 0) begin
      prev_lt_cur = $signed(prev_data) < $signed(dm_rdata);
      prev_gt_cur = $signed(prev_data) > $signed(dm_rdata);
    end else begin
      prev_lt_cur = prev_data < dm_rdata;
      prev_gt_cur = prev_data > dm_rdata;
    end
    in_order = (ORDER != 0) ? prev_gt_cur : prev_lt_cur;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RUN;
      idx         <= '0;
      prev_data   <= '0;
      fail_code   <= FC_NONE;
      fail_index  <= '0;
      cycle_count <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          cycle_count <= cnt_next;
          // End PC takes priority over both overflow and timeout; the
          // overflow raised by the final instruction is the expected one.
          if (end_hit) begin
            if (Overflow && (EXPECT_OVF == 0)) begin
              fail_code <= FC_OVF;
              state     <= ST_DONE;
            end else begin
              if (!Overflow && (EXPECT_OVF != 0)) begin
                fail_code <= FC_MISSOVF;
              end
              state <= ST_SCAN;
            end
          end else if (Overflow) begin
            fail_code <= FC_OVF;
            state     <= ST_DONE;
          end else if (timeout_hit) begin
            fail_code <= FC_TIMEOUT;
            state     <= ST_DONE;
          end
        end

        ST_SCAN: begin
          if (data_valid) begin
            prev_data <= dm_rdata;
          end
          // Earlier failures (code 3) are kept; only the first violation
          // is recorded, but the scan always runs to the end.
          if (cmp_valid && !in_order && (fail_code == FC_NONE)) begin
            fail_code  <= FC_ORDER;
            fail_index <= 16'(idx - ONE_I);
          end
          if (idx == LAST_I) begin
            state <= ST_DONE;
          end else begin
            idx <= idx + ONE_I;
          end
        end

        ST_DONE: begin
          state <= ST_DONE;
        end

        default: begin
          state <= ST_DONE;
        end
      endcase
    end
  end

  assign done = (state == ST_DONE);
  assign pass = done && (fail_code == FC_NONE);

endmodule

// File: tb/tb_cpu_run_checker.sv
// tb_cpu_run_checker
// Purpose: scoreboard bench for cpu_run_checker. Six instances with different
// parameter sets share clock and reset. Each instance gets its own PC/Overflow
// trace and data memory. A reference model derives the expected verdict, cycle
// count, completion edge and read-address list from the trace and memory.
// A monitor pops and compares those values when the DUTs present reads or done.
// Ports: none (top-level bench).

module tb_cpu_run_checker;

  localparam int NI     = 6;
  localparam int MAXL   = 48;
  localparam int END_PC = 104;

  localparam int P_LEN [NI] = '{12, 12, 3, 3, 1, 0};
  localparam int P_EO  [NI] = '{1, 1, 1, 1, 0, 1};
  localparam int P_OR  [NI] = '{0, 0, 1, 1, 0, 1};
  localparam int P_SG  [NI] = '{1, 1, 1, 0, 0, 1};
  localparam int P_TO  [NI] = '{100000, 50, 100000, 100000, 1000, 30};
  localparam int P_CW  [NI] = '{32, 32, 32, 32, 4, 32};

  localparam int M_NORMAL = 0;
  localparam int M_OVFMID = 1;
  localparam int M_MISS   = 2;
  localparam int M_HANG   = 3;
  localparam int D_SORTED = 0;
  localparam int D_DUP    = 1;
  localparam int D_RAND   = 2;

  typedef struct {
    int     code;
    int     index;
    longint cnt;
    int     dedge;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] pc     [NI];
  logic        ovf    [NI];
  logic        rd_en  [NI];
  logic [31:0] addr   [NI];
  logic [31:0] rdata  [NI];
  logic        done   [NI];
  logic        pass   [NI];
  logic [2:0]  code   [NI];
  logic [15:0] findex [NI];
  logic [31:0] cnt    [NI];
  logic [3:0]  cnt_e;

  logic [31:0] mem   [NI][256];
  logic [31:0] tr_pc [NI][MAXL];
  logic        tr_ov [NI][MAXL];
  int          tr_len [NI];

  exp_t        exp_q  [NI][$];
  logic [31:0] addr_q [NI][$];
  bit          seen   [NI];
  bit          mon_en;
  int          ecount;
  int          n_cmp;
  int          n_bad;

  assign cnt[4] = {28'd0, cnt_e};

  cpu_run_checker u_a (
    .clk(clk), .rst(rst), .PC(pc[0]), .Overflow(ovf[0]), .dm_rd_en(rd_en[0]),
    .dm_addr(addr[0]), .dm_rdata(rdata[0]), .done(done[0]), .pass(pass[0]),
    .fail_code(code[0]), .fail_index(findex[0]), .cycle_count(cnt[0]));

  cpu_run_checker #(.TIMEOUT(50)) u_b (
    .clk(clk), .rst(rst), .PC(pc[1]), .Overflow(ovf[1]), .dm_rd_en(rd_en[1]),
    .dm_addr(addr[1]), .dm_rdata(rdata[1]), .done(done[1]), .pass(pass[1]),
    .fail_code(code[1]), .fail_index(findex[1]), .cycle_count(cnt[1]));

  cpu_run_checker #(.ARR_LEN(3), .ORDER(1)) u_c (
    .clk(clk), .rst(rst), .PC(pc[2]), .Overflow(ovf[2]), .dm_rd_en(rd_en[2]),
    .dm_addr(addr[2]), .dm_rdata(rdata[2]), .done(done[2]), .pass(pass[2]),
    .fail_code(code[2]), .fail_index(findex[2]), .cycle_count(cnt[2]));

  cpu_run_checker #(.ARR_LEN(3), .ORDER(1), .SIGNED_CMP(0)) u_d (
    .clk(clk), .rst(rst), .PC(pc[3]), .Overflow(ovf[3]), .dm_rd_en(rd_en[3]),
    .dm_addr(addr[3]), .dm_rdata(rdata[3]), .done(done[3]), .pass(pass[3]),
    .fail_code(code[3]), .fail_index(findex[3]), .cycle_count(cnt[3]));

  cpu_run_checker #(.ARR_LEN(1), .EXPECT_OVF(0), .SIGNED_CMP(0), .TIMEOUT(1000),
                    .CNT_WIDTH(4)) u_e (
    .clk(clk), .rst(rst), .PC(pc[4]), .Overflow(ovf[4]), .dm_rd_en(rd_en[4]),
    .dm_addr(addr[4]), .dm_rdata(rdata[4]), .done(done[4]), .pass(pass[4]),
    .fail_code(code[4]), .fail_index(findex[4]), .cycle_count(cnt_e));

  cpu_run_checker #(.ARR_LEN(0), .TIMEOUT(30), .ORDER(1)) u_f (
    .clk(clk), .rst(rst), .PC(pc[5]), .Overflow(ovf[5]), .dm_rd_en(rd_en[5]),
    .dm_addr(addr[5]), .dm_rdata(rdata[5]), .done(done[5]), .pass(pass[5]),
    .fail_code(code[5]), .fail_index(findex[5]), .cycle_count(cnt[5]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read data memory: data appears the cycle after the strobe.
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (rd_en[k]) rdata[k] <= mem[k][addr[k][9:2]];
    end
  end

  // Edge number since reset release: edge 1 samples trace entry 0.
  always @(posedge clk) ecount <= rst ? 0 : ecount + 1;

  task automatic chk(string nm, int k, longint act, longint expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s inst%0d: got %0d, expected %0d", nm, k, act, expv);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model(int k);
    exp_t        x;
    int          e;
    int          j;
    int          slen;
    bit          scan;
    bit          ok;
    longint      maxc;
    logic [31:0] a;
    logic [31:0] b;
    maxc    = (longint'(1) << P_CW[k]) - 1;
    x.code  = 0;
    x.index = 0;
    scan    = 0;
    for (e = 1; e < 200000; e++) begin
      j = (e - 1 < tr_len[k]) ? e - 1 : tr_len[k] - 1;
      if (tr_pc[k][j] == END_PC) begin
        if (tr_ov[k][j] && P_EO[k] == 0) x.code = 1;
        else begin
          scan = 1;
          if (!tr_ov[k][j] && P_EO[k] != 0) x.code = 3;
        end
        break;
      end
      if (tr_ov[k][j]) begin
        x.code = 1;
        break;
      end
      if (longint'(e) == longint'(P_TO[k]) - 1 && longint'(e) <= maxc) begin
        x.code = 2;
        break;
      end
    end
    x.cnt = (longint'(e) < maxc) ? longint'(e) : maxc;
    slen  = (P_LEN[k] <= 1) ? 1 : P_LEN[k] + 1;
    x.dedge = scan ? e + slen : e;
    if (scan) begin
      for (int i = 0; i < P_LEN[k]; i++) addr_q[k].push_back(32'(512 + 4 * i));
      for (int i = 1; i < P_LEN[k]; i++) begin
        a = mem[k][128 + i - 1];
        b = mem[k][128 + i];
        if (P_SG[k] != 0) ok = (P_OR[k] != 0) ? ($signed(a) > $signed(b)) : ($signed(a) < $signed(b));
        else ok = (P_OR[k] != 0) ? (a > b) : (a < b);
        if (!ok && x.code == 0) begin
          x.code  = 4;
          x.index = i;
        end
      end
    end
    exp_q[k].push_back(x);
  endtask

  // ---------------- stimulus generation ----------------
  task automatic gen_trace(int k, int mode, bit pulse40);
    int L;
    int j;
    L = int'($urandom_range(3, 40));
    for (int i = 0; i < L - 1; i++) begin
      tr_pc[k][i] = 32'(4 * $urandom_range(0, 50));
      if (tr_pc[k][i] == END_PC) tr_pc[k][i] = 100;
      tr_ov[k][i] = 1'b0;
    end
    tr_len[k]       = L;
    tr_pc[k][L - 1] = END_PC;
    tr_ov[k][L - 1] = (P_EO[k] != 0);
    if (mode == M_OVFMID) begin
      j = int'($urandom_range(0, L - 2));
      tr_ov[k][j] = 1'b1;
      if (pulse40) tr_pc[k][j] = 40;
    end else if (mode == M_MISS) begin
      tr_ov[k][L - 1] = (P_EO[k] == 0);
    end else if (mode == M_HANG) begin
      tr_pc[k][L - 1] = 36;
      tr_ov[k][L - 1] = 1'b0;
    end
  endtask

  task automatic gen_data(int k, int mode);
    int v [12];
    int n;
    int d;
    n = P_LEN[k];
    v[0] = (P_SG[k] != 0) ? int'($urandom_range(0, 60)) - 30 : int'($urandom_range(0, 60));
    for (int i = 1; i < 12; i++) v[i] = v[i - 1] + int'($urandom_range(1, 10));
    if (mode == D_DUP && n >= 2) begin
      d = int'($urandom_range(1, n - 1));
      v[d] = v[d - 1];
    end
    if (mode == D_RAND) begin
      for (int i = 0; i < 12; i++) v[i] = int'($urandom_range(0, 40)) - 20;
    end
    for (int i = 0; i < n; i++) mem[k][128 + i] = 32'((P_OR[k] != 0) ? v[n - 1 - i] : v[i]);
  endtask

  task automatic set_plan_array(int k);
    int pa [12];
    pa = '{0, 11, 22, 33, 44, 55, 66, 77, 88, 99, 110, 121};
    for (int i = 0; i < 12; i++) mem[k][128 + i] = 32'(pa[i]);
    mem[k][140] = 32'h7fff_ffff;
  endtask

  task automatic set_small_array(int k);
    mem[k][128] = 32'd5;
    mem[k][129] = 32'hffff_ffff;
    mem[k][130] = 32'hffff_fff9;
  endtask

  // ---------------- round control ----------------
  task automatic begin_round();
    int tm;
    mon_en = 1'b0;
    rst    = 1'b1;
    for (int k = 0; k < NI; k++) begin
      pc[k]  = '0;
      ovf[k] = 1'b0;
    end
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("rst_done", k, done[k], 0);
      chk("rst_pass", k, pass[k], 0);
      chk("rst_fail_code", k, code[k], 0);
      chk("rst_cycle_count", k, cnt[k], 0);
      chk("rst_rd_en", k, rd_en[k], 0);
      exp_q[k].delete();
      addr_q[k].delete();
      for (int w = 0; w < 256; w++) mem[k][w] = $urandom;
      tm = int'($urandom_range(0, 5));
      if (tm > M_HANG) tm = M_NORMAL;
      if (tm == M_HANG && !(k == 1 || k == 5)) tm = M_NORMAL;
      gen_trace(k, tm, 1'b0);
      gen_data(k, int'($urandom_range(0, 2)));
    end
  endtask

  function automatic bit all_done();
    for (int k = 0; k < NI; k++) if (exp_q[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive(int c);
    int j;
    for (int k = 0; k < NI; k++) begin
      j = (c < tr_len[k]) ? c : tr_len[k] - 1;
      pc[k]  = tr_pc[k][j];
      ovf[k] = tr_ov[k][j];
    end
  endtask

  task automatic exec_round();
    for (int k = 0; k < NI; k++) begin
      model(k);
      seen[k] = 1'b0;
    end
    drive(0);
    rst    = 1'b0;
    mon_en = 1'b1;
    for (int c = 0; c < 400; c++) begin
      drive(c);
      @(negedge clk);
      if (all_done()) break;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      if (exp_q[k].size() != 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done_wait inst%0d: got done=%0d after cycle budget, expected 1", k, done[k]);
      end
      chk("reads_missing", k, addr_q[k].size(), 0);
    end
    mon_en = 1'b0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t        x;
    logic [31:0] ea;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int k = 0; k < NI; k++) begin
          if (rd_en[k]) begin
            if (addr_q[k].size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL rd_extra inst%0d: got read at %0d, expected no read", k, addr[k]);
            end else begin
              ea = addr_q[k].pop_front();
              chk("rd_addr", k, addr[k], ea);
            end
          end
          if (done[k] && !seen[k]) begin
            seen[k] = 1'b1;
            if (exp_q[k].size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL done_early inst%0d: got done=1, expected none pending", k);
            end else begin
              x = exp_q[k].pop_front();
              chk("fail_code", k, code[k], x.code);
              chk("pass", k, pass[k], (x.code == 0) ? 1 : 0);
              if (x.code == 4) chk("fail_index", k, findex[k], x.index);
              chk("cycle_count", k, cnt[k], x.cnt);
              chk("done_edge", k, ecount, x.dedge);
            end
          end else if (seen[k]) begin
            chk("done_sticky", k, done[k], 1);
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no end of run, expected $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int nscan;
    n_cmp  = 0;
    n_bad  = 0;
    mon_en = 1'b0;
    rst    = 1'b1;
    for (int k = 0; k < NI; k++) begin
      pc[k]  = '0;
      ovf[k] = 1'b0;
    end
    repeat (2) @(negedge clk);

    // sorted array with expected final overflow; small signed/unsigned arrays
    begin_round();
    gen_trace(0, M_NORMAL, 1'b0); set_plan_array(0);
    gen_trace(2, M_NORMAL, 1'b0); set_small_array(2);
    gen_trace(3, M_NORMAL, 1'b0); set_small_array(3);
    exec_round();

    // element 1 forced to 0 -> order violation at index 1
    begin_round();
    gen_trace(0, M_NORMAL, 1'b0); set_plan_array(0);
    mem[0][129] = 32'd0;
    exec_round();

    // overflow pulse at PC=40 -> code 1, no scan
    begin_round();
    gen_trace(0, M_OVFMID, 1'b1); set_plan_array(0);
    exec_round();

    // PC stuck -> timeout at count 49
    begin_round();
    gen_trace(1, M_HANG, 1'b0);
    exec_round();

    // end PC without overflow, sorted array -> code 3, full scan
    begin_round();
    gen_trace(0, M_MISS, 1'b0); set_plan_array(0);
    exec_round();

    repeat (40) begin
      begin_round();
      exec_round();
    end

    // reset asserted mid-scan must clear outputs immediately
    begin_round();
    gen_trace(0, M_NORMAL, 1'b0); set_plan_array(0);
    rst   = 1'b0;
    nscan = 0;
    for (int c = 0; c < 200; c++) begin
      drive(c);
      @(negedge clk);
      if (rd_en[0]) nscan++;
      if (nscan == 4) break;
    end
    chk("midscan_reads", 0, nscan, 4);
    rst = 1'b1;
    #1;
    chk("midscan_rst_done", 0, done[0], 0);
    chk("midscan_rst_pass", 0, pass[0], 0);
    chk("midscan_rst_fail_code", 0, code[0], 0);
    chk("midscan_rst_fail_index", 0, findex[0], 0);
    chk("midscan_rst_cycle_count", 0, cnt[0], 0);
    chk("midscan_rst_rd_en", 0, rd_en[0], 0);
    chk("midscan_rst_dm_addr", 0, addr[0], 0);

    // a normal run after the abort
    begin_round();
    gen_trace(0, M_NORMAL, 1'b0); set_plan_array(0);
    exec_round();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
